mac_tx_sched: RTL and testbench
===============================

Name: mac_tx_sched

Overview:
- Frame-level transmit scheduler in front of the RMII MAC TX FIFO (35-bit entries: [34:32] valid byte count, [31:0] data, byte 0 in [7:0]).
- Shares the transmitter between two word-stream requesters, for example DMA and CPU, using frame-granular round-robin.
- Admits a frame only when the FIFO is empty and the line is idle, so two frames never merge in the FIFO.
- Enforces the inter-frame gap, and detects and cleans up TX underrun.

Parameters:
- IFG_CYCLES, 48, refclk cycles of enforced idle after rmii_txen falls (96 bit times); legal range 1..255.

Ports:
- rmii_refclk  in  1  RMII 50 MHz reference clock
- rstn  in  1  reset
- chN_valid  in  1  requester N word valid (N = 0, 1)
- chN_data  in  32  requester N word
- chN_bytes  in  3  valid bytes in word, 1..4; honoured only with chN_last
- chN_last  in  1  final word of frame
- chN_ready  out  1  word accepted when valid & ready
- fifo_tx_full  in  1  TX FIFO full
- fifo_tx_empty  in  1  TX FIFO empty
- fifo_tx_wr  out  1  FIFO push strobe
- fifo_tx_wdata  out  35  {bytes, data}
- rmii_txen  in  1  monitored TX enable from the MAC interface
- tx_grant  out  2  one-hot current owner, 0 when none
- tx_busy  out  1  state != IDLE
- tx_done  out  1  1-cycle pulse: frame fully sent
- tx_done_ch  out  1  channel of last tx_done or tx_underrun
- tx_underrun  out  1  1-cycle pulse: frame truncated on line

Behaviour:
- Clocking and reset: rstn is an asynchronous, active-low reset; clock is rmii_refclk.
- Reset values: all outputs 0; state IDLE; rr_ptr=0 (ch0 preferred); txen_d1=0; gap counter 0.
- Edge detection: txen_fall = txen_d1 & ~rmii_txen.
- IDLE:
  - Arbitration is eligible when fifo_tx_empty & ~rmii_txen.
  - If any chN_valid, grant the requester per rr_ptr; if both are valid, the rr_ptr channel wins; otherwise the sole valid channel wins.
  - Next cycle: state XFER, tx_grant one-hot, rr_ptr <= ~granted.
  - Arbitration latency is 1 cycle, and no word is accepted in IDLE.
- XFER:
  - ready = granted channel & ~fifo_tx_full; the other channel's ready = 0.
  - On accept: fifo_tx_wr=1 combinationally in the same cycle, wdata={bytes, data}.
  - bytes field is 4 for non-last words. For a last word it is chN_bytes, with 0 or >4 clamped to 4.
  - Last word accepted -> WAIT_TX.
  - txen_fall seen in XFER (FIFO drained mid-frame) -> tx_underrun pulse.
    - If the same cycle also accepts the last word -> GAP.
    - Otherwise -> DROP.
- DROP:
  - ready=1 for the granted channel; words are discarded with no fifo_tx_wr.
  - Last accepted -> GAP.
- WAIT_TX:
  - Hold until txen_fall, then tx_done pulse -> GAP.
  - rmii_txen may stay low arbitrarily long while the MAC defers to RX carrier; no timeout.
- GAP:
  - Counter loads IFG_CYCLES-1 on entry and decrements each cycle.
  - At 0 -> IDLE, tx_grant cleared.
  - Every transition into GAP clears tx_grant, so no grant is held during GAP.
  - Gap is measured from txen_fall, i.e. the first cycle rmii_txen is low after the frame. In the underrun-then-DROP case, it is measured from DROP exit.
- tx_done_ch updates with each tx_done or tx_underrun pulse.
- Requester rules:
  - A requester may deassert valid mid-frame; the scheduler waits.
  - Stalling longer than the FIFO drain time causes underrun.
  - Grant is never switched mid-frame.
- Mid-operation reset: immediate return to reset values. The external FIFO is reset by the same rstn.

Test Plan:
- Single frame: ch0 sends 3 words (last bytes=2), FIFO empty, txen low -> grant=01 after 1 cycle; 3 pushes with wdata[34:32]=4,4,2. After txen falls: tx_done=1, tx_done_ch=0; then 48 idle cycles before any new grant.
- Contention: both channels hold a 2-word frame from reset -> ch0 served first, then ch1. With continuous traffic the grant sequence is 01,10,01,10; a frame never starts while fifo_tx_empty=0 or rmii_txen=1.
- Back-pressure: fifo_tx_full=1 for 5 cycles mid-frame -> ch_ready=0 and no fifo_tx_wr during those cycles; no word lost or duplicated.
- Underrun: ch1 stalls after word 1 until the bench drops rmii_txen -> tx_underrun pulse, tx_done_ch=1. Remaining 3 words are accepted with fifo_tx_wr=0; GAP follows, and there is no tx_done.
- Byte clamp: last word with bytes=0 and then bytes=7 -> written count 4. A non-last word with bytes=1 -> written count 4.
- Reset mid-XFER: rstn low for 1 cycle -> tx_grant=0, tx_busy=0, rr_ptr=0; the next request from either channel is granted from IDLE without a gap.

Source files
------------

// File: rtl/mac_tx_sched.sv
// Frame-granular round-robin TX scheduler in front of the RMII MAC FIFO.
// Admits one frame at a time, enforces the IFG, and drops the tail on underrun.
module mac_tx_sched #(
  parameter int unsigned IFG_CYCLES = 48
) (
  input  logic        rmii_refclk,
  input  logic        rstn,
  input  logic        ch0_valid,
  input  logic [31:0] ch0_data,
  input  logic [2:0]  ch0_bytes,
  input  logic        ch0_last,
  output logic        ch0_ready,
  input  logic        ch1_valid,
  input  logic [31:0] ch1_data,
  input  logic [2:0]  ch1_bytes,
  input  logic        ch1_last,
  output logic        ch1_ready,
  input  logic        fifo_tx_full,
  input  logic        fifo_tx_empty,
  output logic        fifo_tx_wr,
  output logic [34:0] fifo_tx_wdata,
  input  logic        rmii_txen,
  output logic [1:0]  tx_grant,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        tx_done_ch,
  output logic        tx_underrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_XFER,
    S_DROP,
    S_WAIT,
    S_GAP
  } state_t;

  localparam logic [7:0] GAP_LOAD = 8'(IFG_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        rr_ptr_q, rr_ptr_d;
  logic        txen_d1_q;
  logic [7:0]  gap_q, gap_d;
  logic        done_q, done_d;
  logic        unr_q, unr_d;
  logic        done_ch_q, done_ch_d;

  logic        sel;
  logic        c_valid;
  logic [31:0] c_data;
  logic [2:0]  c_bytes;
  logic        c_last;
  logic [2:0]  bcnt;
  logic        txen_fall;
  logic        rdy;
  logic        acc;
  logic        win;

  always_comb begin
    sel       = grant_q[1];
    c_valid   = sel ? ch1_valid : ch0_valid;
    c_data    = sel ? ch1_data  : ch0_data;
    c_bytes   = sel ? ch1_bytes : ch0_bytes;
    c_last    = sel ? ch1_last  : ch0_last;
    txen_fall = txen_d1_q & ~rmii_txen;
    // Byte count is only meaningful on the last word; out-of-range means full.
    if (!c_last || c_bytes == 3'd0 || c_bytes > 3'd4)
      bcnt = 3'd4;
    else
      bcnt = c_bytes;
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    gap_d     = gap_q;
    done_d    = 1'b0;
    unr_d     = 1'b0;
    done_ch_d = done_ch_q;
    rdy       = 1'b0;
    acc       = 1'b0;
    win       = 1'b0;
    fifo_tx_wr = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (fifo_tx_empty && !rmii_txen &&
            (ch0_valid || ch1_valid)) begin
          win      = (ch0_valid && ch1_valid) ? rr_ptr_q : ch1_valid;
          grant_d  = win ? 2'b10 : 2'b01;
          rr_ptr_d = ~win;
          state_d  = S_XFER;
        end
      end
      S_XFER: begin
        rdy        = ~fifo_tx_full;
        acc        = c_valid & rdy;
        fifo_tx_wr = acc;
        if (txen_fall) begin
          unr_d     = 1'b1;
          done_ch_d = sel;
          if (acc && c_last) begin
            state_d = S_GAP;
            grant_d = 2'b00;
            gap_d   = GAP_LOAD;
          end else begin
            state_d = S_DROP;
          end
        end else if (acc && c_last) begin
          state_d = S_WAIT;
        end
      end
      S_DROP: begin
        rdy = 1'b1;
        if (c_valid && c_last) begin
          state_d = S_GAP;
          grant_d = 2'b00;
          gap_d   = GAP_LOAD;
        end
      end
      S_WAIT: begin
        if (txen_fall) begin
          done_d    = 1'b1;
          done_ch_d = sel;
          state_d   = S_GAP;
          grant_d   = 2'b00;
          gap_d     = GAP_LOAD;
        end
      end
      S_GAP: begin
        if (gap_q == 8'd0)
          state_d = S_IDLE;
        else
          gap_d = gap_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge rmii_refclk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      grant_q   <= 2'b00;
      rr_ptr_q  <= 1'b0;
      txen_d1_q <= 1'b0;
      gap_q     <= 8'd0;
      done_q    <= 1'b0;
      unr_q     <= 1'b0;
      done_ch_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      txen_d1_q <= rmii_txen;
      gap_q     <= gap_d;
      done_q    <= done_d;
      unr_q     <= unr_d;
      done_ch_q <= done_ch_d;
    end
  end

  assign ch0_ready     = rdy & grant_q[0];
  assign ch1_ready     = rdy & grant_q[1];
  assign fifo_tx_wdata = fifo_tx_wr ? {bcnt, c_data} : 35'd0;
  assign tx_grant      = grant_q;
  assign tx_busy       = (state_q != S_IDLE);
  assign tx_done       = done_q;
  assign tx_done_ch    = done_ch_q;
  assign tx_underrun   = unr_q;

endmodule

// File: tb/tb_mac_tx_sched.sv
// Directed bench for mac_tx_sched: per-channel scoreboards of expected
// FIFO writes, checked against every fifo_tx_wr strobe.
module tb_mac_tx_sched;

  localparam int IFG = 48;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ch0_valid, ch1_valid;
  logic [31:0] ch0_data, ch1_data;
  logic [2:0]  ch0_bytes, ch1_bytes;
  logic        ch0_last, ch1_last;
  logic        ch0_ready, ch1_ready;
  logic        fifo_tx_full, fifo_tx_empty;
  logic        fifo_tx_wr;
  logic [34:0] fifo_tx_wdata;
  logic        rmii_txen;
  logic [1:0]  tx_grant;
  logic        tx_busy, tx_done, tx_done_ch, tx_underrun;

  int passed = 0;
  int total  = 0;
  int exp_owner = 0;
  int done_cnt = 0;
  int unr_cnt  = 0;
  logic [34:0] q0[$];
  logic [34:0] q1[$];

  always #10 clk = ~clk;

  mac_tx_sched #(.IFG_CYCLES(IFG)) dut (
    .rmii_refclk   (clk),
    .rstn          (rstn),
    .ch0_valid     (ch0_valid),
    .ch0_data      (ch0_data),
    .ch0_bytes     (ch0_bytes),
    .ch0_last      (ch0_last),
    .ch0_ready     (ch0_ready),
    .ch1_valid     (ch1_valid),
    .ch1_data      (ch1_data),
    .ch1_bytes     (ch1_bytes),
    .ch1_last      (ch1_last),
    .ch1_ready     (ch1_ready),
    .fifo_tx_full  (fifo_tx_full),
    .fifo_tx_empty (fifo_tx_empty),
    .fifo_tx_wr    (fifo_tx_wr),
    .fifo_tx_wdata (fifo_tx_wdata),
    .rmii_txen     (rmii_txen),
    .tx_grant      (tx_grant),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done),
    .tx_done_ch    (tx_done_ch),
    .tx_underrun   (tx_underrun)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (tx_done) done_cnt++;
      if (tx_underrun) unr_cnt++;
      if (fifo_tx_wr) begin
        if (exp_owner == 0) begin
          if (q0.size() == 0) chk("wr_unexpected", 64'(fifo_tx_wr), 64'd0);
          else chk("wdata_ch0", 64'(fifo_tx_wdata), 64'(q0.pop_front()));
        end else begin
          if (q1.size() == 0) chk("wr_unexpected", 64'(fifo_tx_wr), 64'd0);
          else chk("wdata_ch1", 64'(fifo_tx_wdata), 64'(q1.pop_front()));
        end
      end
    end
  end

  task automatic drive(input int ch, input logic [31:0] d,
                       input logic [2:0] b, input logic l, input bit push);
    logic [2:0] eb;
    eb = 3'd4;
    if (l && b >= 3'd1 && b <= 3'd4) eb = b;
    if (ch == 0) begin
      ch0_valid = 1'b1; ch0_data = d; ch0_bytes = b; ch0_last = l;
      if (push) q0.push_back({eb, d});
    end else begin
      ch1_valid = 1'b1; ch1_data = d; ch1_bytes = b; ch1_last = l;
      if (push) q1.push_back({eb, d});
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the word is taken.
  task automatic accept(input int ch, input bit nowr);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ((ch == 0) ? ch0_ready : ch1_ready) begin
        got = 1'b1;
        if (nowr) chk("drop_no_wr", 64'(fifo_tx_wr), 64'd0);
        break;
      end
    end
    chk("accept_timeout", 64'(got), 64'd1);
    @(posedge clk); #1;
    if (ch == 0) ch0_valid = 1'b0; else ch1_valid = 1'b0;
  endtask

  task automatic wait_grant(input logic [1:0] exp);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (tx_grant != 2'b00) break;
    end
    chk("grant", 64'(tx_grant), 64'(exp));
  endtask

  task automatic line_tx(input int n);
    fifo_tx_empty = 1'b0;
    rmii_txen = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rmii_txen = 1'b0;
    fifo_tx_empty = 1'b1;
  endtask

  task automatic wait_done(input int ch);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_done) begin got = 1'b1; break; end
    end
    chk("done_seen", 64'(got), 64'd1);
    chk("done_ch", 64'(tx_done_ch), 64'(ch));
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    ch0_valid = 1'b0; ch1_valid = 1'b0;
    ch0_data = '0; ch1_data = '0;
    ch0_bytes = '0; ch1_bytes = '0;
    ch0_last = 1'b0; ch1_last = 1'b0;
    fifo_tx_full = 1'b0; fifo_tx_empty = 1'b1; rmii_txen = 1'b0;
    q0.delete(); q1.delete();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit got;
    int d0;
    int u0;

    // Reset values
    rstn = 1'b0;
    ch0_valid = 1'b0; ch1_valid = 1'b0;
    ch0_data = '0; ch1_data = '0;
    ch0_bytes = '0; ch1_bytes = '0;
    ch0_last = 1'b0; ch1_last = 1'b0;
    fifo_tx_full = 1'b0; fifo_tx_empty = 1'b1; rmii_txen = 1'b0;
    @(negedge clk);
    chk("rst_grant", 64'(tx_grant), 64'd0);
    chk("rst_busy", 64'(tx_busy), 64'd0);
    chk("rst_done", 64'(tx_done), 64'd0);
    chk("rst_unr", 64'(tx_underrun), 64'd0);
    chk("rst_done_ch", 64'(tx_done_ch), 64'd0);
    chk("rst_wr", 64'(fifo_tx_wr), 64'd0);
    chk("rst_wdata", 64'(fifo_tx_wdata), 64'd0);
    chk("rst_rdy0", 64'(ch0_ready), 64'd0);
    chk("rst_rdy1", 64'(ch1_ready), 64'd0);
    @(posedge clk); #1 rstn = 1'b1;

    // Single frame, ch0, 3 words
    exp_owner = 0;
    drive(0, 32'hA000_0001, 3'd4, 1'b0, 1'b1);
    @(negedge clk);
    chk("idle_no_ready", 64'(ch0_ready), 64'd0);
    chk("idle_no_grant", 64'(tx_grant), 64'd0);
    @(posedge clk); #1;
    chk("grant_lat1", 64'(tx_grant), 64'd1);
    accept(0, 1'b0);
    drive(0, 32'hA000_0002, 3'd4, 1'b0, 1'b1);
    accept(0, 1'b0);
    drive(0, 32'hA000_0003, 3'd2, 1'b1, 1'b1);
    accept(0, 1'b0);
    chk("sb_drain1", 64'(q0.size()), 64'd0);
    chk("wait_busy", 64'(tx_busy), 64'd1);
    line_tx(5);
    wait_done(0);
    drive(0, 32'hA100_0001, 3'd4, 1'b1, 1'b1);
    cnt = 0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_grant != 2'b00) begin got = 1'b1; break; end
      cnt++;
    end
    chk("ifg_regrant", 64'(got), 64'd1);
    chk("ifg_min", 64'(cnt >= IFG), 64'd1);
    chk("ifg_grant", 64'(tx_grant), 64'd1);

    // Contention with round-robin
    do_reset();
    drive(0, 32'hC000_0000, 3'd4, 1'b0, 1'b1);
    drive(1, 32'hC100_0001, 3'd4, 1'b0, 1'b1);
    for (int f = 0; f < 4; f++) begin
      int o;
      o = f % 2;
      exp_owner = o;
      wait_grant((o == 0) ? 2'b01 : 2'b10);
      accept(o, 1'b0);
      drive(o, 32'hD000_0000 | 32'(f), 3'd3, 1'b1, 1'b1);
      accept(o, 1'b0);
      line_tx(4);
      wait_done(o);
      if (f < 2) drive(o, 32'hC000_0000 | 32'(f + 2), 3'd4, 1'b0, 1'b1);
      if (f == 0) begin
        fifo_tx_empty = 1'b0;
        repeat (60) @(negedge clk);
        chk("blk_empty", 64'(tx_grant), 64'd0);
        chk("blk_idle", 64'(tx_busy), 64'd0);
        fifo_tx_empty = 1'b1;
        rmii_txen = 1'b1;
        repeat (10) @(negedge clk);
        chk("blk_txen", 64'(tx_grant), 64'd0);
        rmii_txen = 1'b0;
      end
    end
    chk("sb_rr0", 64'(q0.size()), 64'd0);
    chk("sb_rr1", 64'(q1.size()), 64'd0);

    // Back-pressure
    do_reset();
    exp_owner = 0;
    drive(0, 32'hB000_0000, 3'd4, 1'b0, 1'b1);
    wait_grant(2'b01);
    accept(0, 1'b0);
    drive(0, 32'hB000_0001, 3'd4, 1'b0, 1'b1);
    accept(0, 1'b0);
    drive(0, 32'hB000_0002, 3'd4, 1'b0, 1'b1);
    fifo_tx_full = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_ready", 64'(ch0_ready), 64'd0);
      chk("bp_wr", 64'(fifo_tx_wr), 64'd0);
    end
    @(posedge clk); #1 fifo_tx_full = 1'b0;
    accept(0, 1'b0);
    drive(0, 32'hB000_0003, 3'd1, 1'b1, 1'b1);
    accept(0, 1'b0);
    chk("sb_bp", 64'(q0.size()), 64'd0);
    line_tx(3);
    wait_done(0);

    // Underrun on ch1
    do_reset();
    exp_owner = 1;
    drive(1, 32'hE000_0000, 3'd4, 1'b0, 1'b1);
    wait_grant(2'b10);
    accept(1, 1'b0);
    d0 = done_cnt;
    u0 = unr_cnt;
    rmii_txen = 1'b1;
    fifo_tx_empty = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rmii_txen = 1'b0;
    fifo_tx_empty = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_underrun) begin got = 1'b1; break; end
    end
    chk("unr_seen", 64'(got), 64'd1);
    chk("unr_ch", 64'(tx_done_ch), 64'd1);
    chk("unr_grant", 64'(tx_grant), 64'd2);
    @(posedge clk); #1;
    drive(1, 32'hE000_0001, 3'd4, 1'b0, 1'b0);
    accept(1, 1'b1);
    drive(1, 32'hE000_0002, 3'd4, 1'b0, 1'b0);
    accept(1, 1'b1);
    drive(1, 32'hE000_0003, 3'd2, 1'b1, 1'b0);
    accept(1, 1'b1);
    chk("gap_nogrant", 64'(tx_grant), 64'd0);
    chk("gap_busy", 64'(tx_busy), 64'd1);
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!tx_busy) begin got = 1'b1; break; end
    end
    chk("unr_to_idle", 64'(got), 64'd1);
    chk("unr_no_done", 64'(done_cnt), 64'(d0));
    chk("unr_once", 64'(unr_cnt), 64'(u0 + 1));

    // Byte-count clamp
    do_reset();
    exp_owner = 0;
    drive(0, 32'h1111_0000, 3'd1, 1'b0, 1'b1);
    wait_grant(2'b01);
    accept(0, 1'b0);
    drive(0, 32'h1111_0001, 3'd0, 1'b1, 1'b1);
    accept(0, 1'b0);
    chk("sb_clamp0", 64'(q0.size()), 64'd0);
    line_tx(3);
    wait_done(0);
    drive(0, 32'h2222_0000, 3'd7, 1'b1, 1'b1);
    wait_grant(2'b01);
    accept(0, 1'b0);
    chk("sb_clamp7", 64'(q0.size()), 64'd0);
    line_tx(3);
    wait_done(0);

    // Reset in the middle of a transfer
    do_reset();
    exp_owner = 0;
    drive(0, 32'h3333_0000, 3'd4, 1'b0, 1'b1);
    wait_grant(2'b01);
    accept(0, 1'b0);
    drive(0, 32'h3333_0001, 3'd4, 1'b0, 1'b0);
    rstn = 1'b0;
    @(negedge clk);
    chk("mrst_grant", 64'(tx_grant), 64'd0);
    chk("mrst_busy", 64'(tx_busy), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    q0.delete();
    drive(0, 32'h4444_0000, 3'd4, 1'b1, 1'b1);
    drive(1, 32'h5555_0000, 3'd4, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("mrst_rr0", 64'(tx_grant), 64'd1);
    accept(0, 1'b0);
    chk("sb_mrst", 64'(q0.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
